// File: rtl/dmem_pkg.sv
// dmem_pkg: definitions shared by the data memory and the future cache.
//   - access size encodings SZ_BYTE / SZ_HALF / SZ_WORD / SZ_ILL
//   - controller state enum state_t
//   - lane_en(): byte-lane write enables for a size and byte offset
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_IDLE  = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  // A halfword always occupies lanes {lane[1],0} and {lane[1],1}.
  // The illegal size enables no lanes.
  function automatic logic [3:0] lane_en(input logic [1:0] size,
                                         input logic [1:0] lane);
    logic [3:0] be;
    case (size)
      SZ_BYTE: be = 4'b0001 << lane;
      SZ_HALF: be = lane[1] ? 4'b1100 : 4'b0011;
      SZ_WORD: be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/dmem_sized_lane_align.sv
// dmem_lane_align: combinational byte-lane steering for the data memory.
// Store side: lane enables and the store data replicated into every lane.
// Load side: selected byte or halfword, right-justified, then sign- or
// zero-extended.
// Ports:
//   i_size     access size (dmem_pkg encodings)
//   i_lane     byte offset within the word (addr[1:0])
//   i_unsigned 1 = zero-extend loads, 0 = sign-extend
//   i_wdata    raw store data (byte/half taken from the low bits)
//   i_rword    word currently stored at the addressed index
//   o_be       byte-lane write enables
//   o_wdata    store data with the byte/half present in every lane
//   o_rdata    extended load result
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]  i_size,
  input  logic [1:0]  i_lane,
  input  logic        i_unsigned,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rword,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic [31:0] o_rdata
);

  logic        [31:0] w_shift;
  logic signed [7:0]  w_byte;
  logic signed [15:0] w_half;

  // Replicating the byte/half into every lane means the lane enables alone
  // decide where it lands; no data shifter is needed on the store path.
  always_comb begin
    o_be = lane_en(i_size, i_lane);
    case (i_size)
      SZ_BYTE: o_wdata = {4{i_wdata[7:0]}};
      SZ_HALF: o_wdata = {2{i_wdata[15:0]}};
      default: o_wdata = i_wdata;
    endcase
  end

  assign w_shift = i_rword >> {i_lane, 3'b000};
  assign w_byte  = w_shift[7:0];
  assign w_half  = w_shift[15:0];

  always_comb begin
    case (i_size)
      SZ_BYTE: o_rdata = i_unsigned ? {24'h0, w_byte} : {{24{w_byte[7]}}, w_byte};
      SZ_HALF: o_rdata = i_unsigned ? {16'h0, w_half} : {{16{w_half[15]}}, w_half};
      default: o_rdata = w_shift;
    endcase
  end

endmodule

// File: rtl/dmem_sized.sv
// dmem_sized: parametrised byte/half/word data memory with a valid/ready
// request/response handshake and programmable wait states.
// Optional feature: define DMEM_CLEAR_ON_RESET_EN to zero the whole array
// (one word per cycle) after every reset before accepting requests.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   req_valid/req_ready           request handshake
//   req_write, req_size,
//   req_unsigned, addr, wdata     request fields
//   resp_valid/resp_ready         response handshake
//   rdata, resp_err               response fields
module dmem_sized
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH       = 32,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0080,
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] rdata,
  output logic        resp_err
);

  localparam int          IW        = $clog2(DEPTH);
  localparam logic [31:0] SPAN      = 32'(DEPTH * 4);
  localparam logic [3:0]  WAIT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
`ifdef DMEM_CLEAR_ON_RESET_EN
  localparam state_t      RST_STATE = ST_CLEAR;
`else
  localparam state_t      RST_STATE = ST_IDLE;
`endif

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic        r_write;
  logic [1:0]  r_size;
  logic        r_uns;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;
  logic        r_err;
  logic [31:0] r_mem [DEPTH];
`ifdef DMEM_CLEAR_ON_RESET_EN
  logic [IW-1:0] r_clr_idx;
`endif

  logic          w_sel_in;
  logic          w_write;
  logic [1:0]    w_size;
  logic          w_uns;
  logic [31:0]   w_addr;
  logic [31:0]   w_wdata;
  logic [31:0]   w_off;
  logic [IW-1:0] w_idx;
  logic          w_inrange;
  logic          w_misalign;
  logic          w_err;
  logic          w_perform;
  logic          w_mem_we;
  logic [3:0]    w_be;
  logic [31:0]   w_wsh;
  logic [31:0]   w_rword;
  logic [31:0]   w_ldata;
  logic [31:0]   w_result;

  // With zero wait states the access happens on the acceptance edge, so the
  // datapath must see the live request; otherwise it uses the latched copy.
  assign w_sel_in = (r_state == ST_IDLE);
  assign w_write  = w_sel_in ? req_write    : r_write;
  assign w_size   = w_sel_in ? req_size     : r_size;
  assign w_uns    = w_sel_in ? req_unsigned : r_uns;
  assign w_addr   = w_sel_in ? addr         : r_addr;
  assign w_wdata  = w_sel_in ? wdata        : r_wdata;

  // An address below the base wraps to a huge offset, but the explicit
  // lower-bound compare keeps the intent obvious.
  assign w_off     = w_addr - BASE_ADDR;
  assign w_inrange = (w_addr >= BASE_ADDR) && (w_off < SPAN);
  assign w_idx     = w_off[IW+1:2];

  always_comb begin
    case (w_size)
      SZ_BYTE: w_misalign = 1'b0;
      SZ_HALF: w_misalign = w_addr[0];
      SZ_WORD: w_misalign = |w_addr[1:0];
      default: w_misalign = 1'b1;
    endcase
  end

  assign w_err     = !w_inrange || w_misalign;
  assign w_perform = ((r_state == ST_IDLE) && req_valid && (WAIT_CYCLES == 0)) ||
                     ((r_state == ST_WAIT) && (r_cnt == 4'd0));
  assign w_mem_we  = w_perform && w_write && !w_err;
  assign w_rword   = r_mem[w_idx];
  assign w_result  = (w_err || w_write) ? 32'h0 : w_ldata;

  dmem_lane_align u_align (
    .i_size     (w_size),
    .i_lane     (w_addr[1:0]),
    .i_unsigned (w_uns),
    .i_wdata    (w_wdata),
    .i_rword    (w_rword),
    .o_be       (w_be),
    .o_wdata    (w_wsh),
    .o_rdata    (w_ldata)
  );

  // Storage: reset suppresses the pending write, so an abandoned access
  // never reaches the array.
  always_ff @(posedge clk) begin
    if (!rst) begin
`ifdef DMEM_CLEAR_ON_RESET_EN
      if (r_state == ST_CLEAR)
        r_mem[r_clr_idx] <= 32'h0;
`endif
      if (w_mem_we) begin
        for (int i = 0; i < 4; i++) begin
          if (w_be[i])
            r_mem[w_idx][8*i +: 8] <= w_wsh[8*i +: 8];
        end
      end
    end
  end

  // Controller: request latch, wait counter and registered response.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= RST_STATE;
      r_cnt     <= 4'd0;
      r_rdata   <= 32'h0;
      r_err     <= 1'b0;
`ifdef DMEM_CLEAR_ON_RESET_EN
      r_clr_idx <= '0;
`endif
    end else begin
      case (r_state)
`ifdef DMEM_CLEAR_ON_RESET_EN
        ST_CLEAR: begin
          r_clr_idx <= r_clr_idx + 1'b1;
          if (r_clr_idx == IW'(DEPTH - 1))
            r_state <= ST_IDLE;
        end
`endif
        ST_IDLE: begin
          if (req_valid) begin
            r_write <= req_write;
            r_size  <= req_size;
            r_uns   <= req_unsigned;
            r_addr  <= addr;
            r_wdata <= wdata;
            if (WAIT_CYCLES == 0) begin
              r_rdata <= w_result;
              r_err   <= w_err;
              r_state <= ST_RESP;
            end else begin
              r_cnt   <= WAIT_INIT;
              r_state <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (r_cnt == 4'd0) begin
            r_rdata <= w_result;
            r_err   <= w_err;
            r_state <= ST_RESP;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        ST_RESP: begin
          if (resp_ready) begin
            r_rdata <= 32'h0;
            r_err   <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign req_ready  = (r_state == ST_IDLE);
  assign resp_valid = (r_state == ST_RESP);
  assign rdata      = r_rdata;
  assign resp_err   = r_err;

endmodule

// File: tb/tb_dmem_sized.sv
// Testbench for dmem_sized (DEPTH=32, BASE_ADDR=0x80, WAIT_CYCLES=3).
// Expected responses are queued when a request is driven and popped when
// the DUT presents its response.
module tb_dmem_sized;
  import dmem_pkg::*;

  localparam int          DEPTH = 32;
  localparam logic [31:0] BASE  = 32'h0000_0080;
  localparam int          WAITC = 3;
`ifdef DMEM_CLEAR_ON_RESET_EN
  localparam bit CLR = 1'b1;
`else
  localparam bit CLR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = 2'b10;
  logic        req_unsigned = 1'b0;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] rdata;
  logic        resp_err;

  typedef struct {
    logic [31:0] rd;
    logic        err;
  } exp_t;

  exp_t sb_q[$];
  int   n_pass  = 0;
  int   n_fail  = 0;
  int   n_total = 0;

  always #5 clk = ~clk;

  dmem_sized #(
    .DEPTH       (DEPTH),
    .BASE_ADDR   (BASE),
    .WAIT_CYCLES (WAITC)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_write    (req_write),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .addr         (addr),
    .wdata        (wdata),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .rdata        (rdata),
    .resp_err     (resp_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge: holds rst for 'cycles' edges, checks the reset
  // outputs, releases reset and checks when requests are accepted again.
  task automatic do_reset(input int cycles);
    int n;
    rst = 1'b1;
    req_valid = 1'b0;
    resp_ready = 1'b0;
    repeat (cycles) @(negedge clk);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_rdata", rdata, 0);
    check("rst_resp_err", resp_err, 0);
    rst = 1'b0;
    #1;
`ifdef DMEM_CLEAR_ON_RESET_EN
    check("clr_ready_low", req_ready, 0);
    n = 0;
    while (!req_ready && n < DEPTH + 20) begin
      @(negedge clk);
      n++;
    end
    check("clr_cycles", n, DEPTH);
`else
    n = 0;
    check("rst_ready_high", req_ready, 1);
`endif
  endtask

  // Issue one request, compare its response against the queued expectation,
  // optionally stall the response for 'hold' cycles, then take it.
  task automatic access(input string tag, input logic wr, input logic [1:0] sz,
                        input logic uns, input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] erd, input logic eerr, input int hold);
    exp_t e;
    exp_t got;
    int   n;
    e.rd  = erd;
    e.err = eerr;
    sb_q.push_back(e);
    @(negedge clk);
    req_valid = 1'b1;
    req_write = wr;
    req_size = sz;
    req_unsigned = uns;
    addr = a;
    wdata = wd;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_accept"}, 32'(n < 50), 1);
    @(negedge clk);
    req_valid = 1'b0;
    n = 0;
    while (!resp_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_latency"}, n, WAITC);
    got = sb_q.pop_front();
    check({tag, "_rdata"}, rdata, got.rd);
    check({tag, "_err"}, resp_err, got.err);
    for (int i = 0; i < hold; i++) begin
      // A store offered while the response is pending must be ignored.
      req_valid = 1'b1;
      req_write = 1'b1;
      req_size = SZ_WORD;
      addr = 32'h0000_008C;
      wdata = 32'h5555_5555;
      @(negedge clk);
      check({tag, "_hold_valid"}, resp_valid, 1);
      check({tag, "_hold_ready"}, req_ready, 0);
      check({tag, "_hold_rdata"}, rdata, got.rd);
      check({tag, "_hold_err"}, resp_err, got.err);
    end
    req_valid = 1'b0;
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    check({tag, "_taken"}, resp_valid, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1);
  end

  initial begin
    int n;
    @(negedge clk);
    do_reset(3);

    if (CLR) begin
      for (int i = 0; i < DEPTH; i++)
        access("clr_word", 0, SZ_WORD, 0, BASE + 32'(4 * i), 32'h0, 32'h0, 0, 0);
    end

    // word store/load
    access("sw80", 1, SZ_WORD, 0, 32'h80, 32'hDEAD_BEEF, 32'h0, 0, 0);
    access("lw80", 0, SZ_WORD, 0, 32'h80, 32'h0, 32'hDEAD_BEEF, 0, 0);

    // byte lanes and extension
    access("sw84", 1, SZ_WORD, 0, 32'h84, 32'h1122_3344, 32'h0, 0, 0);
    access("sb85", 1, SZ_BYTE, 0, 32'h85, 32'hABCD_EF7F, 32'h0, 0, 0);
    access("lw84a", 0, SZ_WORD, 0, 32'h84, 32'h0, 32'h1122_7F44, 0, 0);
    access("lb86", 0, SZ_BYTE, 0, 32'h86, 32'h0, 32'h0000_0022, 0, 0);
    access("sb87", 1, SZ_BYTE, 0, 32'h87, 32'h1234_5680, 32'h0, 0, 0);
    access("lb87", 0, SZ_BYTE, 0, 32'h87, 32'h0, 32'hFFFF_FF80, 0, 0);
    access("lbu87", 0, SZ_BYTE, 1, 32'h87, 32'h0, 32'h0000_0080, 0, 0);
    access("lw84b", 0, SZ_WORD, 0, 32'h84, 32'h0, 32'h8022_7F44, 0, 0);

    // halfword lanes and extension
    access("sw88", 1, SZ_WORD, 0, 32'h88, 32'hCAFE_F00D, 32'h0, 0, 0);
    access("sh8a", 1, SZ_HALF, 0, 32'h8A, 32'h7777_8001, 32'h0, 0, 0);
    access("lw88", 0, SZ_WORD, 0, 32'h88, 32'h0, 32'h8001_F00D, 0, 0);
    access("lh8a", 0, SZ_HALF, 0, 32'h8A, 32'h0, 32'hFFFF_8001, 0, 0);
    access("lhu8a", 0, SZ_HALF, 1, 32'h8A, 32'h0, 32'h0000_8001, 0, 0);
    access("lh88", 0, SZ_HALF, 0, 32'h88, 32'h0, 32'hFFFF_F00D, 0, 0);

    // error cases: nothing written, rdata 0
    access("lh81", 0, SZ_HALF, 0, 32'h81, 32'h0, 32'h0, 1, 0);
    access("lw7c", 0, SZ_WORD, 0, 32'h7C, 32'h0, 32'h0, 1, 0);
    access("lw_top", 0, SZ_WORD, 0, BASE + 32'(4 * DEPTH), 32'h0, 32'h0, 1, 0);
    access("lb7f", 0, SZ_BYTE, 0, 32'h7F, 32'h0, 32'h0, 1, 0);
    access("lill", 0, SZ_ILL, 0, 32'h80, 32'h0, 32'h0, 1, 0);
    access("sw82", 1, SZ_WORD, 0, 32'h82, 32'h9999_9999, 32'h0, 1, 0);
    access("sw_top", 1, SZ_WORD, 0, BASE + 32'(4 * DEPTH), 32'h9999_9999, 32'h0, 1, 0);
    access("sill", 1, SZ_ILL, 0, 32'h80, 32'h9999_9999, 32'h0, 1, 0);
    access("sh89", 1, SZ_HALF, 0, 32'h89, 32'h9999_9999, 32'h0, 1, 0);
    access("lw80_keep", 0, SZ_WORD, 0, 32'h80, 32'h0, 32'hDEAD_BEEF, 0, 0);
    access("lw84_keep", 0, SZ_WORD, 0, 32'h84, 32'h0, 32'h8022_7F44, 0, 0);
    access("lw88_keep", 0, SZ_WORD, 0, 32'h88, 32'h0, 32'h8001_F00D, 0, 0);

    // stalled response; a request offered meanwhile is ignored
    access("sw8c", 1, SZ_WORD, 0, 32'h8C, 32'h1234_5678, 32'h0, 0, 0);
    access("lw8c_hold", 0, SZ_WORD, 0, 32'h8C, 32'h0, 32'h1234_5678, 0, 5);
    access("lw8c_keep", 0, SZ_WORD, 0, 32'h8C, 32'h0, 32'h1234_5678, 0, 0);

    // reset while a store waits: the store is abandoned
    access("sw90", 1, SZ_WORD, 0, 32'h90, 32'h0BAD_F00D, 32'h0, 0, 0);
    @(negedge clk);
    req_valid = 1'b1;
    req_write = 1'b1;
    req_size = SZ_WORD;
    addr = 32'h90;
    wdata = 32'hA5A5_A5A5;
    @(negedge clk);
    req_valid = 1'b0;
    check("midwait_ready", req_ready, 0);
    @(negedge clk);
    do_reset(1);
    access("lw90_after", 0, SZ_WORD, 0, 32'h90, 32'h0, CLR ? 32'h0 : 32'h0BAD_F00D, 0, 0);
    access("lw80_after", 0, SZ_WORD, 0, 32'h80, 32'h0, CLR ? 32'h0 : 32'hDEAD_BEEF, 0, 0);

    // reset while a load response is pending
    @(negedge clk);
    req_valid = 1'b1;
    req_write = 1'b0;
    req_size = SZ_WORD;
    addr = 32'h88;
    @(negedge clk);
    req_valid = 1'b0;
    n = 0;
    while (!resp_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("resp_rst_latency", n, WAITC);
    check("resp_rst_rdata", rdata, CLR ? 32'h0 : 32'h8001_F00D);
    do_reset(1);
    access("lw88_after", 0, SZ_WORD, 0, 32'h88, 32'h0, CLR ? 32'h0 : 32'h8001_F00D, 0, 0);

    check("sb_drained", sb_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
